// File: rtl/physics_pkg.sv
// physics_pkg: shared types for the OBB collision pair scheduler.
//  obb_t     192-bit body record (16.16 position/extents, 2.14 axes)
//  vec2_t    2.14 signed vector
//  contact_t {idx_a, idx_b, normal, pen} contact record
//  state_t   scheduler FSM states
package physics_pkg;
    localparam int MAX_BODIES = 16;
    localparam int IDX_W = 4;
    localparam int FIFO_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pos_x;
        logic [31:0] pos_y;
        logic [15:0] u_x;
        logic [15:0] u_y;
        logic [15:0] v_x;
        logic [15:0] v_y;
        logic [31:0] half_w;
        logic [31:0] half_h;
    } obb_t;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
    } vec2_t;

    typedef struct packed {
        logic [IDX_W-1:0]   idx_a;
        logic [IDX_W-1:0]   idx_b;
        vec2_t              normal;
        logic signed [31:0] pen;
    } contact_t;

    typedef enum logic [2:0] {IDLE, RD_A, WAIT_A, RD_B, WAIT_B, EVAL, DRAIN} state_t;
endpackage

// File: rtl/contact_fifo.sv
// contact_fifo: register-array FIFO holding contacts for the impulse solver.
//  Clk, Reset      clock, asynchronous active-high reset (empties the FIFO)
//  push, din       write an entry (ignored when full)
//  pop             retire the head entry (ignored when empty)
//  dout            head entry, stable until popped
//  empty, full     occupancy flags
module contact_fifo
    import physics_pkg::*;
#(
    parameter int  DEPTH = FIFO_DEPTH,
    parameter type T     = contact_t
) (
    input  logic Clk,
    input  logic Reset,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic empty,
    output logic full
);
    localparam int AW = $clog2(DEPTH);

    T mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/collision_pair_scheduler.sv
// collision_pair_scheduler: walks all body pairs (i<j) through the OBB detector and queues contacts.
//  Clk, Reset                  clock, asynchronous active-high reset
//  start, body_count           pass request and body count (sampled on accepted start)
//  busy, done                  pass in progress / one-cycle completion pulse
//  body_rd_en/addr/data        body RAM read port, data one cycle after the strobe
//  det_obb_a/b                 registered bodies presented to the detector
//  det_is_collision/normal/pen detector result, sampled only in EVAL
//  contact_valid/ready/data    contact FIFO head handshake
//  pairs_tested                pairs evaluated in the current or last pass
module collision_pair_scheduler
    import physics_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [IDX_W:0]     body_count,
    output logic               busy,
    output logic               done,
    output logic               body_rd_en,
    output logic [IDX_W-1:0]   body_rd_addr,
    input  obb_t               body_rd_data,
    output obb_t               det_obb_a,
    output obb_t               det_obb_b,
    input  logic               det_is_collision,
    input  vec2_t              det_normal,
    input  logic [31:0]        det_pen,
    output logic               contact_valid,
    input  logic               contact_ready,
    output contact_t           contact_data,
    output logic [2*IDX_W-1:0] pairs_tested
);
    state_t state, state_nx;
    logic [IDX_W:0]   n;
    logic [IDX_W-1:0] i, j;
    logic empty, full, push, stall, col_more, row_more;

    assign col_more      = {1'b0, j} < n - (IDX_W+1)'(1);
    assign row_more      = {1'b0, i} < n - (IDX_W+1)'(2);
    // A colliding pair with nowhere to go holds the FSM in EVAL.
    assign stall         = det_is_collision && full;
    assign push          = (state == EVAL) && det_is_collision && !full;
    assign contact_valid = !empty;

    always_comb begin
        state_nx     = state;
        busy         = state != IDLE;
        done         = 1'b0;
        body_rd_en   = 1'b0;
        body_rd_addr = i;
        case (state)
            IDLE:    if (start) state_nx = (body_count < (IDX_W+1)'(2)) ? DRAIN : RD_A;
            RD_A:    begin body_rd_en = 1'b1; state_nx = WAIT_A; end
            WAIT_A:  state_nx = RD_B;
            RD_B:    begin body_rd_en = 1'b1; body_rd_addr = j; state_nx = WAIT_B; end
            WAIT_B:  state_nx = EVAL;
            EVAL:    if (!stall) state_nx = col_more ? RD_B : row_more ? RD_A : DRAIN;
            DRAIN:   if (empty) begin done = 1'b1; state_nx = IDLE; end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            n            <= '0;
            i            <= '0;
            j            <= '0;
            det_obb_a    <= '0;
            det_obb_b    <= '0;
            pairs_tested <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    // Counts above the RAM size are clamped so indices never wrap.
                    n            <= (body_count > (IDX_W+1)'(MAX_BODIES)) ? (IDX_W+1)'(MAX_BODIES) : body_count;
                    i            <= '0;
                    pairs_tested <= '0;
                end
                WAIT_A: begin
                    det_obb_a <= body_rd_data;
                    j         <= i + IDX_W'(1);
                end
                WAIT_B: det_obb_b <= body_rd_data;
                EVAL: if (!stall) begin
                    pairs_tested <= pairs_tested + (2*IDX_W)'(1);
                    if (col_more) j <= j + IDX_W'(1);
                    else if (row_more) i <= i + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    contact_fifo #(.DEPTH(FIFO_DEPTH), .T(contact_t)) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push),
        .din   (contact_t'{i, j, det_normal, det_pen}),
        .pop   (contact_valid && contact_ready),
        .dout  (contact_data),
        .empty (empty),
        .full  (full)
    );
endmodule

// File: tb/tb_collision_pair_scheduler.sv
// tb_collision_pair_scheduler: randomized bench with body RAM, detector model and contact scoreboard.
module tb_collision_pair_scheduler;
    import physics_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [IDX_W:0]     body_count = '0;
    logic               busy, done, body_rd_en;
    logic [IDX_W-1:0]   body_rd_addr;
    obb_t               body_rd_data = '0;
    obb_t               det_obb_a, det_obb_b;
    logic               det_is_collision;
    vec2_t              det_normal;
    logic [31:0]        det_pen;
    logic               contact_valid;
    logic               contact_ready = 1'b1;
    contact_t           contact_data;
    logic [2*IDX_W-1:0] pairs_tested;

    obb_t     bodies [MAX_BODIES];
    bit       coll [MAX_BODIES][MAX_BODIES];
    bit       force_pen = 1'b0;
    bit       rand_ready = 1'b0;
    contact_t exp_q [$];
    int       n_checks = 0, n_pass = 0, rd_cnt = 0, pop_cnt = 0;

    collision_pair_scheduler dut (
        .Clk              (clk),
        .Reset            (rst),
        .start            (start),
        .body_count       (body_count),
        .busy             (busy),
        .done             (done),
        .body_rd_en       (body_rd_en),
        .body_rd_addr     (body_rd_addr),
        .body_rd_data     (body_rd_data),
        .det_obb_a        (det_obb_a),
        .det_obb_b        (det_obb_b),
        .det_is_collision (det_is_collision),
        .det_normal       (det_normal),
        .det_pen          (det_pen),
        .contact_valid    (contact_valid),
        .contact_ready    (contact_ready),
        .contact_data     (contact_data),
        .pairs_tested     (pairs_tested)
    );

    always #5 clk = ~clk;

    // Body RAM: one-cycle read latency. Each body carries its index in pos_x[3:0].
    always @(posedge clk) if (body_rd_en) body_rd_data <= bodies[body_rd_addr];

    // Detector model: collision from a pair table keyed by the body tags; result fields derived from the bodies.
    assign det_is_collision = coll[det_obb_a.pos_x[IDX_W-1:0]][det_obb_b.pos_x[IDX_W-1:0]];
    assign det_pen          = force_pen ? 32'h0080_0000 : det_obb_a.pos_y ^ det_obb_b.pos_y;
    assign det_normal       = vec2_t'{det_obb_a.u_x, det_obb_b.v_y};

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        contact_t e;
        if (body_rd_en) rd_cnt++;
        if (!rst && contact_valid && contact_ready) begin
            e = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check("contact", contact_data, e);
            pop_cnt++;
        end
    end

    always @(posedge clk) if (rand_ready) #1 contact_ready = 1'($urandom_range(0, 1));

    // mode 0: every pair collides; 1: random pairs; 2: only pair (1,3)
    task automatic setup(input int n, input int mode);
        for (int k = 0; k < MAX_BODIES; k++) begin
            bodies[k] = obb_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            bodies[k].pos_x[IDX_W-1:0] = IDX_W'(k);
            for (int m = 0; m < MAX_BODIES; m++)
                coll[k][m] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (k == 1 && m == 3);
        end
        exp_q.delete();
        pop_cnt = 0;
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                if (coll[a][b])
                    exp_q.push_back(contact_t'{IDX_W'(a), IDX_W'(b), vec2_t'{bodies[a].u_x, bodies[b].v_y},
                                               force_pen ? 32'h0080_0000 : bodies[a].pos_y ^ bodies[b].pos_y});
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        body_count = (IDX_W+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 3000);
        check({tag, "_done"}, done, 1);
    endtask

    task automatic reset_checks(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
        check({p, "_rd_en"}, body_rd_en, 0);
        check({p, "_rd_addr"}, body_rd_addr, 0);
        check({p, "_obb_a"}, det_obb_a, 0);
        check({p, "_obb_b"}, det_obb_b, 0);
        check({p, "_valid"}, contact_valid, 0);
        check({p, "_pairs"}, pairs_tested, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, rd0, seen, n;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        rst = 1'b0;

        setup(3, 0);
        pulse_start(3);
        wait_done("n3", cyc);
        check("n3_pairs", pairs_tested, 3);
        check("n3_pops", pop_cnt, 3);
        check("n3_left", exp_q.size(), 0);
        @(posedge clk); #1;
        check("n3_busy_after", busy, 0);

        force_pen = 1'b1;
        setup(4, 2);
        pulse_start(4);
        wait_done("n4", cyc);
        check("n4_pairs", pairs_tested, 6);
        check("n4_pops", pop_cnt, 1);
        check("n4_left", exp_q.size(), 0);
        force_pen = 1'b0;

        @(posedge clk); #1;
        contact_ready = 1'b0;
        setup(5, 0);
        pulse_start(5);
        repeat (150) @(negedge clk);
        check("stall_pairs", pairs_tested, 8);
        check("stall_busy", busy, 1);
        check("stall_valid", contact_valid, 1);
        check("stall_head", contact_data, exp_q[0]);
        repeat (20) @(negedge clk);
        check("stall_pairs_hold", pairs_tested, 8);
        check("stall_head_hold", contact_data, exp_q[0]);
        @(posedge clk); #1;
        contact_ready = 1'b1;
        wait_done("n5", cyc);
        check("n5_pairs", pairs_tested, 10);
        check("n5_pops", pop_cnt, 10);
        check("n5_left", exp_q.size(), 0);

        for (int t = 1; t >= 0; t--) begin
            setup(t, 0);
            rd0 = rd_cnt;
            pulse_start(t);
            wait_done("small", cyc);
            check("small_latency_ok", cyc <= 2, 1);
            check("small_reads", rd_cnt - rd0, 0);
            check("small_pops", pop_cnt, 0);
            check("small_pairs", pairs_tested, 0);
        end

        @(posedge clk); #1;
        contact_ready = 1'b0;
        setup(6, 0);
        pulse_start(6);
        seen = 0;
        cyc = 0;
        while (seen < 8 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (body_rd_en) seen++;
        end
        check("mid_reads", seen, 8);
        check("mid_rdb_addr", body_rd_addr, 2);
        check("mid_fifo_filled", contact_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        reset_checks("mid_rst");
        rst = 1'b0;
        exp_q.delete();
        contact_ready = 1'b1;
        setup(6, 1);
        pulse_start(6);
        wait_done("fresh6", cyc);
        check("fresh6_pairs", pairs_tested, 15);
        check("fresh6_left", exp_q.size(), 0);

        setup(4, 1);
        pulse_start(4);
        repeat (7) @(posedge clk);
        #1;
        check("busy_mid", busy, 1);
        start = 1'b1;
        body_count = 5'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart", cyc);
        check("restart_pairs", pairs_tested, 6);
        check("restart_left", exp_q.size(), 0);

        rand_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(2, 9);
            setup(n, 1);
            pulse_start(n);
            wait_done("rand", cyc);
            check("rand_pairs", pairs_tested, n * (n - 1) / 2);
            check("rand_left", exp_q.size(), 0);
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        contact_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
